// File: rtl/hdub_core_logic_gate_pkg.sv
// Shared op encoding for the logic gate datapath and everything that issues into it.
package hdub_core_logic_gate;

  localparam int GATE_OP_W = 2;

  // Code 2'd3 is deliberately left unassigned; the arbiter flags it as an error.
  typedef enum logic [GATE_OP_W-1:0] {
    GATE_AND = 2'd0,
    GATE_OR  = 2'd1,
    GATE_XOR = 2'd2
  } gate_op_t;

endpackage

// File: rtl/hdub_core_logic_bin_gate_factory.sv
// One bitwise binary gate whose function is fixed at elaboration time by GATE_TYPE.
module HDubCoreLogicBinGateFactory
  import hdub_core_logic_gate::*;
#(
  parameter gate_op_t GATE_TYPE = GATE_AND,
  parameter int       DATA_W    = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    case (GATE_TYPE)
      GATE_AND: y = a & b;
      GATE_OR:  y = a | b;
      GATE_XOR: y = a ^ b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/hdub_core_logic_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, searching from rr_ptr upward with wrap.
module hdub_core_logic_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Explicit wrap so a non-power-of-two NUM_REQ never leaves an out-of-range pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hdub_core_logic_gate_arbiter.sv
// Shares one AND/OR/XOR unit among NUM_REQ requesters with round-robin issue and a
// single registered result slot. Handshake: a beat moves when valid && ready are both high.
module hdub_core_logic_gate_arbiter
  import hdub_core_logic_gate::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][GATE_OP_W-1:0] req_op,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_b,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [DATA_W-1:0]                 res_data,
  output logic [ID_W-1:0]                   res_id,
  output logic                              res_err
);

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;
  logic                 can_issue;
  logic                 transfer;
  logic [GATE_OP_W-1:0] sel_op;
  logic [DATA_W-1:0]    sel_a, sel_b;
  logic [DATA_W-1:0]    and_y, or_y, xor_y;
  logic [DATA_W-1:0]    nxt_data;
  logic                 nxt_err;

  hdub_core_logic_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(ID_W)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The slot may refill in the same cycle it drains, so back-to-back results have no bubble.
  assign can_issue = !res_valid || res_ready;
  assign req_ready = (can_issue && !rst) ? grant : '0;
  assign transfer  = grant_any && can_issue && !rst;

  assign sel_op = req_op[grant_idx];
  assign sel_a  = req_a[grant_idx];
  assign sel_b  = req_b[grant_idx];

  HDubCoreLogicBinGateFactory #(.GATE_TYPE(GATE_AND), .DATA_W(DATA_W)) u_and (.a(sel_a), .b(sel_b), .y(and_y));
  HDubCoreLogicBinGateFactory #(.GATE_TYPE(GATE_OR),  .DATA_W(DATA_W)) u_or  (.a(sel_a), .b(sel_b), .y(or_y));
  HDubCoreLogicBinGateFactory #(.GATE_TYPE(GATE_XOR), .DATA_W(DATA_W)) u_xor (.a(sel_a), .b(sel_b), .y(xor_y));

  always_comb begin
    nxt_data = '0;
    nxt_err  = 1'b0;
    case (sel_op)
      GATE_AND: nxt_data = and_y;
      GATE_OR:  nxt_data = or_y;
      GATE_XOR: nxt_data = xor_y;
      default:  nxt_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
    end else if (transfer) begin
      res_valid <= 1'b1;
      res_data  <= nxt_data;
      res_id    <= grant_idx;
      res_err   <= nxt_err;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdub_core_logic_gate_arbiter.sv
// Directed bench for the gate arbiter: a 4-requester and a 3-requester instance, with
// expected results queued at issue time and compared by monitors on each result handshake.
module tb_hdub_core_logic_gate_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [3:0]         req_valid4 = '0;
  logic [3:0]         req_ready4;
  logic [3:0][1:0]    req_op4    = '0;
  logic [3:0][DW-1:0] req_a4     = '0;
  logic [3:0][DW-1:0] req_b4     = '0;
  logic               res_valid4;
  logic               res_ready4 = 1'b1;
  logic [DW-1:0]      res_data4;
  logic [1:0]         res_id4;
  logic               res_err4;

  // 3-requester instance
  logic [2:0]         req_valid3 = '0;
  logic [2:0]         req_ready3;
  logic [2:0][1:0]    req_op3    = '0;
  logic [2:0][DW-1:0] req_a3     = '0;
  logic [2:0][DW-1:0] req_b3     = '0;
  logic               res_valid3;
  logic               res_ready3 = 1'b1;
  logic [DW-1:0]      res_data3;
  logic [1:0]         res_id3;
  logic               res_err3;

  hdub_core_logic_gate_arbiter #(.NUM_REQ(4), .DATA_W(DW)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_op(req_op4),
    .req_a(req_a4), .req_b(req_b4),
    .res_valid(res_valid4), .res_ready(res_ready4), .res_data(res_data4),
    .res_id(res_id4), .res_err(res_err4)
  );

  hdub_core_logic_gate_arbiter #(.NUM_REQ(3), .DATA_W(DW)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
    .req_a(req_a3), .req_b(req_b3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .res_id(res_id3), .res_err(res_err3)
  );

  // Expected entry: {err, id[1:0], data[31:0]}
  localparam int EW = 35;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp3_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic err, input logic [1:0] id, input logic [DW-1:0] d);
    return {err, id, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: a result is consumed when valid && ready at the coming edge.
  always @(negedge clk) begin
    if (!rst && res_valid4 && res_ready4) begin
      if (exp_q.size() == 0) begin
        check("res4_unexpected", 64'({res_err4, res_id4, res_data4}), 64'h0);
        if ({res_err4, res_id4, res_data4} == '0) begin
          n_fail++;
          $display("FAIL res4_unexpected: got result with empty expected queue at %0t", $time);
        end
      end else begin
        check("res4", 64'({res_err4, res_id4, res_data4}), 64'(exp_q.pop_front()));
      end
    end
    if (!rst && res_valid3 && res_ready3) begin
      if (exp3_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL res3_unexpected: got %0h expected none at %0t",
                 {res_err3, res_id3, res_data3}, $time);
      end else begin
        check("res3", 64'({res_err3, res_id3, res_data3}), 64'(exp3_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst = 1'b1;
    tick(2);
    check("rst_req_ready", 64'(req_ready4), 64'h0);
    check("rst_res_valid", 64'(res_valid4), 64'h0);
    check("rst_res_data",  64'(res_data4),  64'h0);
    check("rst_res_id",    64'(res_id4),    64'h0);
    check("rst_res_err",   64'(res_err4),   64'h0);
    rst = 1'b0;

    // 1: single AND from requester 0
    req_op4[0] = 2'd0; req_a4[0] = 32'hF0F0_F0F0; req_b4[0] = 32'hFF00_FF00;
    req_valid4 = 4'b0001;
    exp_q.push_back(ent(1'b0, 2'd0, 32'hF000_F000));
    #1 check("t1_req_ready", 64'(req_ready4), 64'h1);
    tick(1);
    req_valid4 = '0;
    check("t1_res_valid", 64'(res_valid4), 64'h1);
    tick(1);
    check("t1_res_drop", 64'(res_valid4), 64'h0);

    // 2: all requesters valid, full rotation with no bubbles
    rst = 1'b1; tick(1); rst = 1'b0;
    req_op4[0] = 2'd0; req_a4[0] = 32'h1234_5678; req_b4[0] = 32'h0F0F_0F0F;
    req_op4[1] = 2'd1; req_a4[1] = 32'hA000_0000; req_b4[1] = 32'h0000_0005;
    req_op4[2] = 2'd2; req_a4[2] = 32'hFFFF_FFFF; req_b4[2] = 32'h0000_FFFF;
    req_op4[3] = 2'd0; req_a4[3] = 32'hDEAD_BEEF; req_b4[3] = 32'hFFFF_0000;
    exp_q.push_back(ent(1'b0, 2'd0, 32'h0204_0608));
    exp_q.push_back(ent(1'b0, 2'd1, 32'hA000_0005));
    exp_q.push_back(ent(1'b0, 2'd2, 32'hFFFF_0000));
    exp_q.push_back(ent(1'b0, 2'd3, 32'hDEAD_0000));
    exp_q.push_back(ent(1'b0, 2'd0, 32'h0204_0608));
    req_valid4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("t2_no_bubble", 64'(res_valid4), 64'h1);
    end
    req_valid4 = '0;
    tick(1);
    check("t2_res_drop", 64'(res_valid4), 64'h0);

    // 3: backpressure; rr_ptr is now 1
    res_ready4 = 1'b0;
    req_op4[1] = 2'd1; req_a4[1] = 32'h0000_00F0; req_b4[1] = 32'h0000_000F;
    req_op4[2] = 2'd2; req_a4[2] = 32'hAAAA_AAAA; req_b4[2] = 32'h5555_5555;
    exp_q.push_back(ent(1'b0, 2'd1, 32'h0000_00FF));
    exp_q.push_back(ent(1'b0, 2'd2, 32'hFFFF_FFFF));
    req_valid4 = 4'b0110;
    #1 check("t3_first_grant", 64'(req_ready4), 64'b0010);
    tick(1);
    req_valid4 = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_hold_ready", 64'(req_ready4), 64'h0);
      check("t3_hold_id",    64'(res_id4),    64'h1);
      check("t3_hold_data",  64'(res_data4),  64'h0000_00FF);
      tick(1);
    end
    res_ready4 = 1'b1;
    #1 check("t3_same_cycle_grant", 64'(req_ready4), 64'b0100);
    tick(1);
    req_valid4 = '0;
    check("t3_valid_stays", 64'(res_valid4), 64'h1);
    check("t3_new_id",      64'(res_id4),    64'h2);
    tick(1);
    check("t3_res_drop", 64'(res_valid4), 64'h0);

    // 4: unsupported op then XOR from requester 2
    req_op4[2] = 2'd3; req_a4[2] = 32'hFFFF_FFFF; req_b4[2] = 32'hFFFF_FFFF;
    exp_q.push_back(ent(1'b1, 2'd2, 32'h0));
    req_valid4 = 4'b0100;
    tick(1);
    check("t4_err_set",  64'(res_err4),  64'h1);
    check("t4_err_data", 64'(res_data4), 64'h0);
    req_op4[2] = 2'd2; req_a4[2] = 32'hFFFF_0000; req_b4[2] = 32'h0F0F_0F0F;
    exp_q.push_back(ent(1'b0, 2'd2, 32'hF0F0_0F0F));
    tick(1);
    req_valid4 = '0;
    check("t4_err_clear", 64'(res_err4),  64'h0);
    check("t4_xor_data",  64'(res_data4), 64'hF0F0_0F0F);
    tick(1);

    // 5: reset while a result is held and requests pend
    res_ready4 = 1'b0;
    req_op4[0] = 2'd0; req_a4[0] = 32'hFFFF_FFFF; req_b4[0] = 32'h1357_9BDF;
    req_op4[3] = 2'd1; req_a4[3] = 32'h1;         req_b4[3] = 32'h2;
    req_valid4 = 4'b1111;
    tick(1);
    check("t5_held_valid", 64'(res_valid4), 64'h1);
    rst = 1'b1;
    #1 check("t5_rst_ready", 64'(req_ready4), 64'h0);
    tick(1);
    check("t5_rst_valid", 64'(res_valid4), 64'h0);
    check("t5_rst_data",  64'(res_data4),  64'h0);
    check("t5_rst_id",    64'(res_id4),    64'h0);
    check("t5_rst_err",   64'(res_err4),   64'h0);
    rst = 1'b0;
    res_ready4 = 1'b1;
    exp_q.push_back(ent(1'b0, 2'd0, 32'h1357_9BDF));
    #1 check("t5_first_grant", 64'(req_ready4), 64'b0001);
    tick(1);
    req_valid4 = '0;
    tick(1);

    // 6: NUM_REQ=3, move pointer to 2 then alternate requesters 2 and 0
    req_op3[0] = 2'd0; req_a3[0] = 32'hFF00_00FF; req_b3[0] = 32'h0F0F_0F0F;
    req_op3[1] = 2'd1; req_a3[1] = 32'h0000_0001; req_b3[1] = 32'h0000_0002;
    req_op3[2] = 2'd2; req_a3[2] = 32'h1111_1111; req_b3[2] = 32'h2222_2222;
    exp3_q.push_back(ent(1'b0, 2'd1, 32'h0000_0003));
    req_valid3 = 3'b010;
    tick(1);
    exp3_q.push_back(ent(1'b0, 2'd2, 32'h3333_3333));
    exp3_q.push_back(ent(1'b0, 2'd0, 32'h0F00_000F));
    exp3_q.push_back(ent(1'b0, 2'd2, 32'h3333_3333));
    exp3_q.push_back(ent(1'b0, 2'd0, 32'h0F00_000F));
    req_valid3 = 3'b101;
    #1 check("t6_wrap_grant", 64'(req_ready3), 64'b100);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("t6_no_bubble", 64'(res_valid3), 64'h1);
    end
    req_valid3 = '0;
    tick(1);

    // Drain: all queued expectations must have been consumed
    for (int k = 0; k < 10 && (exp_q.size() != 0 || exp3_q.size() != 0); k++) tick(1);
    check("drain_q4", 64'(exp_q.size()),  64'h0);
    check("drain_q3", 64'(exp3_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
